// File: rtl/frm_window_crop_if.sv
// Frame-interface bundle: one pixel per transfer plus frame/line markers.
//   val/rdy : handshake (transfer when both high on a clk edge)
//   data    : pixel, DATA_WIDTH bits
//   sof/eof : first/last pixel of the frame
//   sol/eol : first/last pixel of the line
// master drives val/data/markers and samples rdy; slave is the mirror.
interface frm_window_crop_if #(
  parameter int unsigned DATA_WIDTH = 24
);
  logic                  val;
  logic                  rdy;
  logic [DATA_WIDTH-1:0] data;
  logic                  sof;
  logic                  eof;
  logic                  sol;
  logic                  eol;

  modport master (output val, data, sof, eof, sol, eol, input rdy);
  modport slave  (input val, data, sof, eof, sol, eol, output rdy);
endinterface

// File: rtl/frm_window_crop.sv
// frm_window_crop: keeps only the pixels of a rectangular window from an
// incoming frame stream and regenerates sof/eof/sol/eol for the cropped image.
// Single output register stage, 1-cycle latency, 1 pixel/cycle.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   cfg_x0, cfg_y0      : window top-left corner (0-based), latched on sof
//   cfg_w, cfg_h        : window size, latched on sof
//   s_frm (slave)       : input pixel stream
//   m_frm (master)      : cropped pixel stream
//   err_short           : sticky error, an input line/frame ended before the
//                         window edge (only when FRM_CROP_ERR_EN is defined)
//
// Optional feature macro: FRM_CROP_ERR_EN
module frm_window_crop #(
  parameter int unsigned DATA_WIDTH = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] cfg_x0,
  input  logic [11:0] cfg_y0,
  input  logic [11:0] cfg_w,
  input  logic [11:0] cfg_h,
  frm_window_crop_if.slave  s_frm,
  frm_window_crop_if.master m_frm
`ifdef FRM_CROP_ERR_EN
  ,
  output logic        err_short
`endif
);

  logic [11:0]           x0_q, x0_d, y0_q, y0_d, w_q, w_d, h_q, h_d;
  logic [11:0]           xcnt_q, xcnt_d, ycnt_q, ycnt_d;
  logic                  m_val_q, m_val_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic                  m_sof_q, m_sof_d, m_eof_q, m_eof_d;
  logic                  m_sol_q, m_sol_d, m_eol_q, m_eol_d;

  logic                  s_rdy;
  logic                  acc;
  logic [11:0]           x0_e, y0_e, w_e, h_e;
  logic [11:0]           xe, ye, xe_inc, ye_inc;
  logic [12:0]           x_end, y_end, x_last, y_last;
  logic                  in_win;
  logic                  at_x_last, at_y_last;

  assign s_rdy = ~m_val_q | m_frm.rdy;

  assign s_frm.rdy  = s_rdy;
  assign m_frm.val  = m_val_q;
  assign m_frm.data = m_data_q;
  assign m_frm.sof  = m_sof_q;
  assign m_frm.eof  = m_eof_q;
  assign m_frm.sol  = m_sol_q;
  assign m_frm.eol  = m_eol_q;

`ifdef FRM_CROP_ERR_EN
  logic err_q, err_d;
  assign err_short = err_q;
`endif

  always_comb begin
    acc = s_frm.val & s_rdy;

    // The sof pixel itself is judged against the incoming config, so the
    // latched copy is bypassed on that pixel.
    x0_e = s_frm.sof ? cfg_x0 : x0_q;
    y0_e = s_frm.sof ? cfg_y0 : y0_q;
    w_e  = s_frm.sof ? cfg_w  : w_q;
    h_e  = s_frm.sof ? cfg_h  : h_q;

    xe = (s_frm.sof | s_frm.sol) ? '0 : xcnt_q;
    ye = s_frm.sof ? '0 : ycnt_q;

    xe_inc = (xe == '1) ? xe : xe + 12'd1;
    ye_inc = (ye == '1) ? ye : ye + 12'd1;

    // 13-bit window bounds so x0+w cannot wrap.
    x_end  = {1'b0, x0_e} + {1'b0, w_e};
    y_end  = {1'b0, y0_e} + {1'b0, h_e};
    x_last = x_end - 13'd1;
    y_last = y_end - 13'd1;

    in_win = (xe >= x0_e) & ({1'b0, xe} < x_end) &
             (ye >= y0_e) & ({1'b0, ye} < y_end);
    at_x_last = ({1'b0, xe} == x_last);
    at_y_last = ({1'b0, ye} == y_last);

    x0_d     = x0_q;
    y0_d     = y0_q;
    w_d      = w_q;
    h_d      = h_q;
    xcnt_d   = xcnt_q;
    ycnt_d   = ycnt_q;
    m_val_d  = m_val_q;
    m_data_d = m_data_q;
    m_sof_d  = m_sof_q;
    m_eof_d  = m_eof_q;
    m_sol_d  = m_sol_q;
    m_eol_d  = m_eol_q;
`ifdef FRM_CROP_ERR_EN
    err_d    = err_q;
`endif

    if (acc) begin
      if (s_frm.sof) begin
        x0_d = cfg_x0;
        y0_d = cfg_y0;
        w_d  = cfg_w;
        h_d  = cfg_h;
      end
      if (s_frm.eol) begin
        xcnt_d = '0;
        ycnt_d = ye_inc;
      end else begin
        xcnt_d = xe_inc;
        ycnt_d = ye;
      end
    end

    if (acc & in_win) begin
      m_val_d  = 1'b1;
      m_data_d = s_frm.data;
      m_sof_d  = (xe == x0_e) & (ye == y0_e);
      m_sol_d  = (xe == x0_e);
      // Input line/frame ending early forces the cropped edge markers.
      m_eol_d  = at_x_last | s_frm.eol;
      m_eof_d  = (at_x_last & at_y_last) | s_frm.eof;
`ifdef FRM_CROP_ERR_EN
      if ((s_frm.eol & ({1'b0, xe} < x_last)) |
          (s_frm.eof & ({1'b0, ye} < y_last)))
        err_d = 1'b1;
`endif
    end else if (m_frm.rdy) begin
      m_val_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x0_q     <= '0;
      y0_q     <= '0;
      w_q      <= '0;
      h_q      <= '0;
      xcnt_q   <= '0;
      ycnt_q   <= '0;
      m_val_q  <= 1'b0;
      m_data_q <= '0;
      m_sof_q  <= 1'b0;
      m_eof_q  <= 1'b0;
      m_sol_q  <= 1'b0;
      m_eol_q  <= 1'b0;
`ifdef FRM_CROP_ERR_EN
      err_q    <= 1'b0;
`endif
    end else begin
      x0_q     <= x0_d;
      y0_q     <= y0_d;
      w_q      <= w_d;
      h_q      <= h_d;
      xcnt_q   <= xcnt_d;
      ycnt_q   <= ycnt_d;
      m_val_q  <= m_val_d;
      m_data_q <= m_data_d;
      m_sof_q  <= m_sof_d;
      m_eof_q  <= m_eof_d;
      m_sol_q  <= m_sol_d;
      m_eol_q  <= m_eol_d;
`ifdef FRM_CROP_ERR_EN
      err_q    <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_frm_window_crop.sv
// Randomised/directed bench for frm_window_crop with a frame-level reference
// model: the expected output is derived from each generated pixel's (x, y)
// position in a well-formed frame and the config captured at its sof.
module tb_frm_window_crop;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] cfg_x0, cfg_y0, cfg_w, cfg_h;

  always #5 clk = ~clk;

  frm_window_crop_if #(.DATA_WIDTH(24)) s_if ();
  frm_window_crop_if #(.DATA_WIDTH(24)) m_if ();

`ifdef FRM_CROP_ERR_EN
  logic err_short;
`endif

  frm_window_crop #(.DATA_WIDTH(24)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_x0    (cfg_x0),
    .cfg_y0    (cfg_y0),
    .cfg_w     (cfg_w),
    .cfg_h     (cfg_h),
    .s_frm     (s_if),
    .m_frm     (m_if)
`ifdef FRM_CROP_ERR_EN
    ,
    .err_short (err_short)
`endif
  );

  typedef struct {
    logic [27:0] vec;   // {data, sof, sol, eol, eof}
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_out = 0;
  int   cyc = 0;
  int   rdy_mode = 0;   // 0: always ready, 1: toggle, 2: random
  bit   lat_chk = 1'b0;
  int   mx0, my0, mw, mh;
  bit   exp_err = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    case (rdy_mode)
      0:       m_if.rdy = 1'b1;
      1:       m_if.rdy = (m_if.rdy === 1'b1) ? 1'b0 : 1'b1;
      default: m_if.rdy = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor / scoreboard.
  bit          hold_prev = 1'b0;
  logic [27:0] prev_vec;
  always @(negedge clk) begin
    logic [27:0] obs;
    exp_t        e;
    #2;
    obs = {m_if.data, m_if.sof, m_if.sol, m_if.eol, m_if.eof};
    if (hold_prev) check_val("hold_stable", {m_if.val, obs}, {1'b1, prev_vec});
    if (m_if.val && !m_if.rdy) check_val("s_rdy_held", s_if.rdy, 0);
    if (m_if.val && m_if.rdy) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_out", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        check_val("pixel", obs, e.vec);
        if (lat_chk) check_val("latency", cyc, e.cyc + 1);
      end
      n_out++;
    end
    hold_prev = m_if.val & ~m_if.rdy;
    prev_vec  = obs;
  end

  task automatic send_px(input logic [23:0] d, input int x, input int y,
                         input int W, input int H, input bit gaps);
    bit   ok;
    bit   done = 1'b0;
    int   c = 0;
    bit   sof = (x == 0) && (y == 0);
    bit   sol = (x == 0);
    bit   eol = (x == W - 1);
    bit   eof = (x == W - 1) && (y == H - 1);
    bit   inw;
    exp_t e;
    if (gaps && $urandom_range(0, 3) == 0) begin
      repeat ($urandom_range(1, 3)) begin
        @(negedge clk);
        s_if.val = 1'b0;
      end
    end
    @(negedge clk);
    s_if.val  = 1'b1;
    s_if.data = d;
    s_if.sof  = sof;
    s_if.sol  = sol;
    s_if.eol  = eol;
    s_if.eof  = eof;
    for (int t = 0; t < 200 && !done; t++) begin
      #1;
      ok = s_if.rdy;
      c  = cyc;
      @(posedge clk);
      if (ok) done = 1'b1;
      else @(negedge clk);
    end
    check_val("accept_timeout", done, 1);
    if (sof) begin
      mx0 = cfg_x0; my0 = cfg_y0; mw = cfg_w; mh = cfg_h;
    end
    inw = (x >= mx0) && (x < mx0 + mw) && (y >= my0) && (y < my0 + mh);
    if (inw) begin
      e.vec = {d, (x == mx0) && (y == my0), (x == mx0),
               (x == mx0 + mw - 1) || eol,
               ((x == mx0 + mw - 1) && (y == my0 + mh - 1)) || eof};
      e.cyc = c;
      exp_q.push_back(e);
      if ((eol && x < mx0 + mw - 1) || (eof && y < my0 + mh - 1)) exp_err = 1'b1;
    end
  endtask

  // Sends pixels with raster index in [first, last] of a W x H frame.
  task automatic send_frame(input int W, input int H, input bit rnd_data,
                            input bit gaps, input int first, input int last);
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        int idx = y * W + x;
        logic [23:0] d = rnd_data ? 24'($urandom()) : 24'(y * 16 + x);
        if (idx >= first && idx <= last) send_px(d, x, y, W, H, gaps);
      end
    end
    @(negedge clk);
    s_if.val = 1'b0;
  endtask

  task automatic drain(input int n_expect, input int base);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      #3;
      n++;
    end
    check_val("drain", exp_q.size(), 0);
    if (n_expect >= 0) check_val("out_count", n_out - base, n_expect);
  endtask

  task automatic check_err();
`ifdef FRM_CROP_ERR_EN
    check_val("err_short", err_short, exp_err);
`endif
  endtask

  task automatic set_cfg(input int x0, input int y0, input int w, input int h);
    cfg_x0 = 12'(x0); cfg_y0 = 12'(y0); cfg_w = 12'(w); cfg_h = 12'(h);
  endtask

  task automatic check_rst_state(input string tag);
    check_val(tag, {m_if.val, m_if.data, m_if.sof, m_if.sol, m_if.eol, m_if.eof}, 0);
`ifdef FRM_CROP_ERR_EN
    check_val({tag, "_err"}, err_short, 0);
`endif
  endtask

  initial begin
    int base;
    rst = 1'b1;
    s_if.val = 1'b0; s_if.data = '0;
    s_if.sof = 1'b0; s_if.sol = 1'b0; s_if.eol = 1'b0; s_if.eof = 1'b0;
    set_cfg(0, 0, 0, 0);
    mx0 = 0; my0 = 0; mw = 0; mh = 0;
    repeat (2) @(posedge clk);
    #1;
    check_rst_state("reset_state");
    @(negedge clk);
    rst = 1'b0;

    // Basic crop.
    rdy_mode = 0; lat_chk = 1'b1; base = n_out;
    set_cfg(2, 1, 3, 2);
    send_frame(8, 4, 0, 0, 0, 31);
    drain(6, base); check_err();

    // Identity.
    base = n_out;
    set_cfg(0, 0, 8, 4);
    send_frame(8, 4, 0, 0, 0, 31);
    drain(32, base); check_err();

    // Backpressure (toggling downstream ready).
    rdy_mode = 1; lat_chk = 1'b0; base = n_out;
    set_cfg(2, 1, 3, 2);
    send_frame(8, 4, 0, 0, 0, 31);
    drain(6, base); check_err();

    // Right-edge clipping.
    rdy_mode = 0; lat_chk = 1'b1; base = n_out;
    set_cfg(6, 0, 4, 4);
    send_frame(8, 4, 0, 0, 0, 31);
    drain(8, base); check_err();

    // Config change mid-frame only takes effect at the next sof.
    base = n_out;
    set_cfg(2, 1, 3, 2);
    send_frame(8, 4, 0, 0, 0, 4);
    cfg_w = 12'd5;
    send_frame(8, 4, 0, 0, 5, 31);
    drain(6, base);
    base = n_out;
    send_frame(8, 4, 0, 0, 0, 31);
    drain(10, base); check_err();

    // Reset after the 2nd output pixel (raster index 11 = data 0x13).
    base = n_out;
    set_cfg(2, 1, 3, 2);
    send_frame(8, 4, 0, 0, 0, 11);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_rst_state("mid_reset");
    check_val("mid_reset_outs", n_out - base, 2);
    exp_q.delete();
    mx0 = 0; my0 = 0; mw = 0; mh = 0; exp_err = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    base = n_out;
    send_frame(8, 4, 0, 0, 12, 31);
    drain(0, base);
    base = n_out;
    send_frame(8, 4, 0, 0, 0, 31);
    drain(6, base); check_err();

    // Randomised frames, geometry, gaps and backpressure.
    rdy_mode = 2; lat_chk = 1'b0;
    for (int f = 0; f < 20; f++) begin
      int W = $urandom_range(1, 10);
      int H = $urandom_range(1, 5);
      set_cfg($urandom_range(0, 10), $urandom_range(0, 5),
              $urandom_range(0, 11), $urandom_range(0, 6));
      send_frame(W, H, 1, 1, 0, W * H - 1);
      drain(-1, 0);
    end
    check_err();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
